// File: rtl/ihp_sram_port_ctrl.sv
// ihp_sram_port_ctrl: fabric port controller for banked IHP SRAM macros.
// Width modes with byte-lane masking, read pipeline, post-config clear.
module ihp_sram_port_ctrl #(
   parameter  int ADDR_WIDTH = 10,
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_BANKS  = 2,
   localparam int BSW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
   localparam int FAW = ADDR_WIDTH + BSW + 2
) (
   input  logic                            UserCLK,
   input  logic                            RST,
   input  logic                            CONFIGURED,
   input  logic [1:0]                      CFG_MODE,
   input  logic                            CFG_OUTREG,
   input  logic                            CFG_CLEAR,
   input  logic [FAW-1:0]                  F_ADDR,
   input  logic [DATA_WIDTH-1:0]           F_DIN,
   input  logic                            F_WEN,
   input  logic                            F_REN,
   output logic [DATA_WIDTH-1:0]           F_DOUT,
   output logic                            F_VALID,
   output logic                            F_BUSY,
   output logic [ADDR_WIDTH-1:0]           ADDR_SRAM,
   output logic [DATA_WIDTH-1:0]           DIN_SRAM,
   output logic [DATA_WIDTH-1:0]           BM_SRAM,
   output logic [NUM_BANKS-1:0]            MEN_SRAM,
   output logic [NUM_BANKS-1:0]            WEN_SRAM,
   output logic [NUM_BANKS-1:0]            REN_SRAM,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] DOUT_SRAM,
   output logic                            CLK_SRAM
);

   localparam int BW = (BSW > 0) ? BSW : 1;
   localparam int HW = DATA_WIDTH / 2;
   localparam int QW = DATA_WIDTH / 4;
   localparam int OW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      S_WAIT,
      S_CLEAR,
      S_RUN
   } state_t;

   state_t                  state;
   state_t                  state_n;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic [ADDR_WIDTH-1:0]   clr_cnt_n;
   logic                    busy_q;
   logic [1:0]              mode_q;
   logic                    outreg_q;
   logic                    accept;

   logic [1:0]              sh;
   logic [OW-1:0]           lane_off;
   logic [DATA_WIDTH-1:0]   base_m;
   logic [DATA_WIDTH-1:0]   din_rep;
   logic [DATA_WIDTH-1:0]   bm_c;
   logic [ADDR_WIDTH-1:0]   word;
   logic [BW-1:0]           bank;
   logic                    in_range;
   logic [NUM_BANKS-1:0]    bank_oh;

   logic                    rd1;
   logic                    rd2;
   logic                    rd3;
   logic [BW-1:0]           bank1;
   logic [BW-1:0]           bank2;
   logic [OW-1:0]           lane_off1;
   logic [OW-1:0]           lane_off2;
   logic [DATA_WIDTH-1:0]   sel;
   logic [DATA_WIDTH-1:0]   dout_c;
   logic [DATA_WIDTH-1:0]   dout_q;

   // Next state: losing configuration always returns to WAIT
   always_comb begin
      state_n   = state;
      clr_cnt_n = '0;
      if (!CONFIGURED) begin
         state_n = S_WAIT;
      end else begin
         unique case (state)
            S_WAIT: state_n = CFG_CLEAR ? S_CLEAR : S_RUN;
            S_CLEAR: begin
               if (clr_cnt == '1) state_n = S_RUN;
               else clr_cnt_n = clr_cnt + 1'b1;
            end
            default: state_n = S_RUN;
         endcase
      end
   end

   // State, clear counter, busy flag and RUN-entry config latch
   always_ff @(posedge UserCLK) begin
      if (RST) begin
         state    <= S_WAIT;
         clr_cnt  <= '0;
         busy_q   <= 1'b1;
         mode_q   <= 2'd0;
         outreg_q <= 1'b0;
      end else begin
         state   <= state_n;
         clr_cnt <= clr_cnt_n;
         busy_q  <= (state != S_RUN) || (state_n != S_RUN);
         if (state_n == S_RUN && state != S_RUN) begin
            mode_q   <= CFG_MODE;
            outreg_q <= CFG_OUTREG;
         end
      end
   end

   assign accept = (state == S_RUN) && !busy_q && (state_n == S_RUN);

   // Width-mode decode: shift, lane offset, lane mask, replicated data
   always_comb begin
      sh       = 2'd0;
      lane_off = '0;
      base_m   = '1;
      din_rep  = F_DIN;
      unique case (mode_q)
         2'd1: begin
            sh       = 2'd1;
            lane_off = F_ADDR[0] ? OW'(HW) : '0;
            base_m   = {{HW{1'b0}}, {HW{1'b1}}};
            din_rep  = {2{F_DIN[HW-1:0]}};
         end
         2'd2: begin
            sh       = 2'd2;
            lane_off = OW'(QW * int'(F_ADDR[1:0]));
            base_m   = {{(DATA_WIDTH-QW){1'b0}}, {QW{1'b1}}};
            din_rep  = {4{F_DIN[QW-1:0]}};
         end
         default: begin
            sh = 2'd0;
         end
      endcase
   end

   assign word = F_ADDR[sh +: ADDR_WIDTH];

   if (BSW > 0) begin : g_bank
      assign bank = F_ADDR[ADDR_WIDTH + sh +: BW];
   end else begin : g_nobank
      assign bank = '0;
   end

   assign in_range = {1'b0, bank} < (BW+1)'(NUM_BANKS);
   assign bank_oh  = in_range ? (NUM_BANKS'(1) << bank) : '0;
   assign bm_c     = base_m << lane_off;

   // Registered macro pins: clear sweep, then user writes and reads
   always_ff @(posedge UserCLK) begin
      if (RST) begin
         MEN_SRAM  <= '0;
         WEN_SRAM  <= '0;
         REN_SRAM  <= '0;
         ADDR_SRAM <= '0;
         DIN_SRAM  <= '0;
         BM_SRAM   <= '0;
      end else begin
         MEN_SRAM <= '0;
         WEN_SRAM <= '0;
         REN_SRAM <= '0;
         BM_SRAM  <= '0;
         if (state_n == S_CLEAR) begin
            MEN_SRAM  <= '1;
            WEN_SRAM  <= '1;
            ADDR_SRAM <= clr_cnt_n;
            DIN_SRAM  <= '0;
            BM_SRAM   <= '1;
         end else if (accept && F_WEN) begin
            MEN_SRAM  <= bank_oh;
            WEN_SRAM  <= bank_oh;
            ADDR_SRAM <= word;
            DIN_SRAM  <= din_rep;
            BM_SRAM   <= bm_c;
         end else if (accept && F_REN) begin
            MEN_SRAM  <= bank_oh;
            REN_SRAM  <= bank_oh;
            ADDR_SRAM <= word;
         end
      end
   end

   // Read pipeline; flushed whenever the next state leaves RUN
   always_ff @(posedge UserCLK) begin
      if (RST || state_n != S_RUN) begin
         rd1       <= 1'b0;
         rd2       <= 1'b0;
         rd3       <= 1'b0;
         bank1     <= '0;
         bank2     <= '0;
         lane_off1 <= '0;
         lane_off2 <= '0;
         dout_q    <= '0;
      end else begin
         rd1       <= accept && F_REN && !F_WEN;
         bank1     <= bank;
         lane_off1 <= lane_off;
         rd2       <= rd1;
         bank2     <= bank1;
         lane_off2 <= lane_off1;
         rd3       <= rd2 && outreg_q;
         dout_q    <= dout_c;
      end
   end

   // Pick the addressed bank and lane; missing banks read as zero
   always_comb begin
      sel = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bank2 == BW'(b)) sel = DOUT_SRAM[b*DATA_WIDTH +: DATA_WIDTH];
      end
      dout_c = rd2 ? ((sel >> lane_off2) & base_m) : '0;
   end

   assign F_DOUT   = outreg_q ? dout_q : dout_c;
   assign F_VALID  = CONFIGURED && (outreg_q ? rd3 : rd2);
   assign F_BUSY   = busy_q;
   assign CLK_SRAM = UserCLK;

endmodule

// File: tb/tb_ihp_sram_port_ctrl.sv
// tb_ihp_sram_port_ctrl: scoreboard bench for ihp_sram_port_ctrl
// with a behavioural three-macro SRAM model on the macro pins.
module tb_ihp_sram_port_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        configured;
   logic [1:0]  cfg_mode;
   logic        cfg_outreg;
   logic        cfg_clear;
   logic [13:0] f_addr;
   logic [31:0] f_din;
   logic        f_wen;
   logic        f_ren;
   logic [31:0] f_dout;
   logic        f_valid;
   logic        f_busy;
   logic [9:0]  addr_s;
   logic [31:0] din_s;
   logic [31:0] bm_s;
   logic [2:0]  men_s;
   logic [2:0]  wen_s;
   logic [2:0]  ren_s;
   logic [95:0] dout_s;
   logic        clk_s;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   logic [31:0] ref_mem [3][1024];
   logic [31:0] mem [3][1024];
   logic [31:0] q_s [3];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [1:0]  cur_mode = 2'd0;
   logic        cur_outreg = 1'b0;

   ihp_sram_port_ctrl #(
      .ADDR_WIDTH(10),
      .DATA_WIDTH(32),
      .NUM_BANKS (3)
   ) dut (
      .UserCLK   (clk),
      .RST       (rst),
      .CONFIGURED(configured),
      .CFG_MODE  (cfg_mode),
      .CFG_OUTREG(cfg_outreg),
      .CFG_CLEAR (cfg_clear),
      .F_ADDR    (f_addr),
      .F_DIN     (f_din),
      .F_WEN     (f_wen),
      .F_REN     (f_ren),
      .F_DOUT    (f_dout),
      .F_VALID   (f_valid),
      .F_BUSY    (f_busy),
      .ADDR_SRAM (addr_s),
      .DIN_SRAM  (din_s),
      .BM_SRAM   (bm_s),
      .MEN_SRAM  (men_s),
      .WEN_SRAM  (wen_s),
      .REN_SRAM  (ren_s),
      .DOUT_SRAM (dout_s),
      .CLK_SRAM  (clk_s)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency expectations
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural macros: masked write, registered read
   always @(posedge clk) begin
      for (int b = 0; b < 3; b++) begin
         if (men_s[b] && wen_s[b])
            mem[b][addr_s] <= (mem[b][addr_s] & ~bm_s) | (din_s & bm_s);
         else if (men_s[b] && ren_s[b])
            q_s[b] <= mem[b][addr_s];
      end
   end

   assign dout_s = {q_s[2], q_s[1], q_s[0]};

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Read-data monitor: pop expected results as F_VALID pulses arrive
   always @(negedge clk) begin
      if (f_valid) begin
         if (sbq.size() == 0) begin
            chk("spurious_valid", 64'(f_valid), 64'd0);
         end else begin
            mon_e = sbq.pop_front();
            chk("rd_cycle", 64'(cyc), 64'(mon_e.due));
            chk("rd_data", 64'(f_dout), 64'(mon_e.data));
         end
      end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
         mon_e = sbq.pop_front();
         chk("valid_missing", 64'(f_valid), 64'd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic we, input logic re,
                      input logic [13:0] a, input logic [31:0] d);
      int          sh;
      int          wid;
      int          lane;
      int          word;
      int          bank;
      logic [63:0] wm;
      logic [63:0] m;
      exp_t        e;
      sh   = (cur_mode == 2'd1) ? 1 : (cur_mode == 2'd2) ? 2 : 0;
      wid  = 32 >> sh;
      lane = int'(a) & ((1 << sh) - 1);
      word = (int'(a) >> sh) & 1023;
      bank = (int'(a) >> (10 + sh)) & 3;
      wm   = (64'd1 << wid) - 64'd1;
      f_addr = a;
      f_din  = d;
      f_wen  = we;
      f_ren  = re;
      if (we) begin
         if (bank < 3) begin
            m = wm << (lane * wid);
            ref_mem[bank][word] = 32'(({32'h0, ref_mem[bank][word]} & ~m) |
                                      (({32'h0, d} & wm) << (lane * wid)));
         end
      end else if (re) begin
         e.data = (bank < 3) ?
                  32'(({32'h0, ref_mem[bank][word]} >> (lane * wid)) & wm) :
                  32'h0;
         e.due  = cyc + 2 + int'(cur_outreg);
         sbq.push_back(e);
      end
      tick();
      f_wen = 1'b0;
      f_ren = 1'b0;
   endtask

   task automatic rnd(input int n);
      for (int i = 0; i < n; i++) begin
         int          sh;
         int          op;
         logic [13:0] a;
         sh = (cur_mode == 2'd1) ? 1 : (cur_mode == 2'd2) ? 2 : 0;
         a  = 14'(((($urandom_range(0, 3) << 10) | $urandom_range(0, 3)) << sh) |
                  ($urandom_range(0, 3) & ((1 << sh) - 1)) |
                  ($urandom_range(0, 3) << (12 + sh)));
         op = $urandom_range(0, 3);
         unique case (op)
            0: req(1'b1, 1'b0, a, $urandom());
            1: req(1'b0, 1'b1, a, 32'h0);
            2: req(1'b1, 1'b1, a, $urandom());
            default: req(1'b0, 1'b0, a, 32'h0);
         endcase
      end
   endtask

   task automatic reconfig(input logic [1:0] m, input logic o);
      repeat (5) tick();
      configured = 1'b0;
      cfg_clear  = 1'b0;
      tick();
      cfg_mode   = m;
      cfg_outreg = o;
      configured = 1'b1;
      tick();
      tick();
      cur_mode   = m;
      cur_outreg = o;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int b = 0; b < 3; b++)
         for (int i = 0; i < 1024; i++) ref_mem[b][i] = 32'h0;
      rst        = 1'b1;
      configured = 1'b0;
      cfg_mode   = 2'd0;
      cfg_outreg = 1'b0;
      cfg_clear  = 1'b0;
      f_addr     = '0;
      f_din      = '0;
      f_wen      = 1'b0;
      f_ren      = 1'b0;

      repeat (2) tick();
      chk("rst_en", 64'({men_s, wen_s, ren_s}), 64'd0);
      chk("rst_pins", {addr_s, din_s, bm_s[21:0]}, 64'd0);
      chk("rst_out", 64'({f_valid, f_dout}), 64'd0);
      chk("rst_busy", 64'(f_busy), 64'd1);

      rst        = 1'b0;
      configured = 1'b1;
      cfg_clear  = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         tick();
         chk("clr_en", 64'({ren_s, wen_s, men_s, addr_s}),
             64'({3'b000, 3'b111, 3'b111, 10'(i)}));
         chk("clr_data", {bm_s, din_s}, {32'hFFFF_FFFF, 32'h0});
      end
      chk("busy_clear_end", 64'(f_busy), 64'd1);
      tick();
      chk("busy_run_first", 64'(f_busy), 64'd1);
      chk("en_after_clear", 64'({men_s, wen_s, ren_s}), 64'd0);
      tick();
      chk("busy_drop", 64'(f_busy), 64'd0);

      req(1'b1, 1'b0, 14'h0405, 32'hDEAD_BEEF);
      chk("wr_full_en", 64'({men_s, wen_s, ren_s}), 64'({3'b010, 3'b010, 3'b000}));
      chk("wr_full_addr", 64'(addr_s), 64'h005);
      chk("wr_full_data", {bm_s, din_s}, {32'hFFFF_FFFF, 32'hDEAD_BEEF});
      req(1'b0, 1'b1, 14'h0405, 32'h0);
      chk("rd_full_en", 64'({men_s, wen_s, ren_s}), 64'({3'b010, 3'b000, 3'b010}));
      chk("rd_full_bm", 64'(bm_s), 64'd0);
      req(1'b0, 1'b1, 14'h0800, 32'h0);
      req(1'b1, 1'b1, 14'h0407, 32'h1234_5678);
      chk("both_en", 64'({men_s, wen_s, ren_s}), 64'({3'b010, 3'b010, 3'b000}));
      req(1'b0, 1'b1, 14'h0C05, 32'h0);
      chk("oor_rd_en", 64'({men_s, wen_s, ren_s}), 64'd0);
      req(1'b1, 1'b0, 14'h0C06, 32'h5555_AAAA);
      chk("oor_wr_en", 64'({men_s, wen_s, ren_s}), 64'd0);
      req(1'b0, 1'b1, 14'h0407, 32'h0);
      rnd(40);

      reconfig(2'd0, 1'b1);
      req(1'b0, 1'b1, 14'h0405, 32'h0);
      req(1'b0, 1'b1, 14'h0C05, 32'h0);
      rnd(40);

      reconfig(2'd2, 1'b0);
      req(1'b1, 1'b0, 14'h0006, 32'h7777_77A5);
      chk("wr_q_en", 64'({men_s, wen_s, ren_s}), 64'({3'b001, 3'b001, 3'b000}));
      chk("wr_q_addr", 64'(addr_s), 64'd1);
      chk("wr_q_data", {bm_s, din_s}, {32'h00FF_0000, 32'hA5A5_A5A5});
      req(1'b0, 1'b1, 14'h0006, 32'h0);
      rnd(40);

      reconfig(2'd1, 1'b1);
      rnd(40);

      reconfig(2'd3, 1'b0);
      rnd(20);
      repeat (5) tick();
      f_addr = 14'h0405;
      f_ren  = 1'b1;
      tick();
      f_ren      = 1'b0;
      configured = 1'b0;
      tick();
      chk("drop_busy", 64'(f_busy), 64'd1);
      chk("drop_valid", 64'(f_valid), 64'd0);
      repeat (4) tick();

      configured = 1'b1;
      cfg_clear  = 1'b1;
      repeat (10) tick();
      chk("mid_clear_wen", 64'(wen_s), 64'b111);
      rst = 1'b1;
      tick();
      chk("rst_clr_en", 64'({men_s, wen_s, ren_s}), 64'd0);
      chk("rst_clr_pins", {addr_s, bm_s, 1'b0, f_busy}, 64'd1);
      rst        = 1'b0;
      configured = 1'b0;
      repeat (3) tick();
      chk("wait_en", 64'({men_s, wen_s, ren_s}), 64'd0);

      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ihp_sram_port_ctrl.md
# ihp_sram_port_ctrl

Parametrised successor to the single-macro IHP SRAM tile interface. It sits between the fabric-side BEL ports of an SRAM supertile and one or more IHP SRAM macros (NUM_BANKS, shared address/data, per-bank enables). Over the fixed 32-bit single-bank port it adds:
- configurable data width (full, half or quarter words) with byte-lane masking,
- a registered read pipeline with an optional extra output stage,
- a post-configuration clear sequencer that zeroes every bank before user access.

## Interface
Parameters:
- ADDR_WIDTH, 10, macro word-address bits
- DATA_WIDTH, 32, macro data width; must be divisible by 4
- NUM_BANKS, 2, macro count, 1..4; BSW = clog2(NUM_BANKS), BSW = 0 when NUM_BANKS = 1
- FAW, ADDR_WIDTH+BSW+2, fabric address width (derived, not overridable)

Ports:
- UserCLK  in  1  fabric user clock; all logic on the rising edge
- RST  in  1  synchronous, active-high reset
- CONFIGURED  in  1  fabric configuration complete
- CFG_MODE  in  2  width mode: 0 = full, 1 = half, 2 = quarter, 3 = full
- CFG_OUTREG  in  1  add output register stage
- CFG_CLEAR  in  1  run the clear sequence after configuration
- F_ADDR  in  FAW  fabric address, in units of the selected width
- F_DIN  in  DATA_WIDTH  write data; the narrow modes use the low W bits
- F_WEN  in  1  write request, single cycle
- F_REN  in  1  read request, single cycle
- F_DOUT  out  DATA_WIDTH  read data, zero-extended in the narrow modes
- F_VALID  out  1  F_DOUT valid, one-cycle pulse
- F_BUSY  out  1  controller is not accepting requests
- ADDR_SRAM  out  ADDR_WIDTH  shared macro address
- DIN_SRAM  out  DATA_WIDTH  shared macro write data
- BM_SRAM  out  DATA_WIDTH  shared bit mask; 1 = bit written
- MEN_SRAM, WEN_SRAM, REN_SRAM  out  NUM_BANKS each  per-bank enables, active-high
- DOUT_SRAM  in  NUM_BANKS*DATA_WIDTH  macro read data, bank b at [b*DATA_WIDTH +: DATA_WIDTH]
- CLK_SRAM  out  1  equal to UserCLK

## Operation
State machine: WAIT, CLEAR, RUN.
- **WAIT**
  - Entered on RST and whenever CONFIGURED = 0 (from any state).
  - Goes to CLEAR when CONFIGURED = 1 and CFG_CLEAR = 1; goes to RUN when CONFIGURED = 1 and CFG_CLEAR = 0.
- **CLEAR**
  - A counter walks addresses 0 .. 2^ADDR_WIDTH-1, one per cycle.
  - Each cycle drives all banks: MEN = WEN = all-ones, REN = 0, BM = all-ones, DIN = 0.
  - Goes to RUN in the cycle after the write of the last address.
- **RUN**
  - CFG_MODE and CFG_OUTREG are latched on entry and held until the next entry into RUN.

Address decode (W = DATA_WIDTH, DATA_WIDTH/2 or DATA_WIDTH/4 for full, half, quarter):
- Full:
  - word = F_ADDR[ADDR_WIDTH-1:0]
  - bank = the next BSW bits
  - top 2 bits ignored
- Half:
  - lane = F_ADDR[0]
  - word = F_ADDR[ADDR_WIDTH:1]
  - bank = the next BSW bits
  - top bit ignored
- Quarter:
  - lane = F_ADDR[1:0]
  - word = F_ADDR[ADDR_WIDTH+1:2]
  - bank = the next BSW bits
- bank >= NUM_BANKS:
  - no enable is driven;
  - a read still produces F_VALID with F_DOUT = 0.

Writes:
- DIN_SRAM = F_DIN[W-1:0] replicated across all lanes.
- BM_SRAM = ones only over bits [lane*W +: W].
- MEN and WEN are set for the selected bank only.

Reads:
- MEN and REN are set for the selected bank only; BM = 0.
- Lane and bank are carried down the pipeline.
- F_DOUT = DOUT_SRAM[bank][lane*W +: W], zero-extended.

Request rules:
- F_WEN and F_REN both high: the write wins and the read is dropped (no F_VALID).
- Requests outside RUN are dropped silently.
- Back-to-back requests are accepted every cycle. There is no backpressure in RUN.
- If CONFIGURED falls with reads in flight, their F_VALID pulses are suppressed.

Reset values:
- All macro enables, ADDR_SRAM, DIN_SRAM, BM_SRAM, F_DOUT and F_VALID are 0.
- F_BUSY = 1; state = WAIT; clear counter = 0.

## Timing
- Macro pins are registered. A request presented in cycle n appears on the macro pins in cycle n+1, and the macro captures it at the end of n+1.
- Read latency:
  - CFG_OUTREG = 0: F_DOUT is combinational from DOUT_SRAM and F_VALID is high in cycle n+2.
  - CFG_OUTREG = 1: F_DOUT is registered and F_VALID is high in cycle n+3.
- Write then read of the same address in cycles n and n+1 returns the new data.
- F_BUSY:
  - It is 1 in WAIT and CLEAR, and also in the first cycle of RUN.
  - It drops to 0 one cycle after RUN is entered; requests are accepted from that cycle.
- Clear duration is exactly 2^ADDR_WIDTH cycles of WEN activity.
- RST asserted mid-CLEAR or mid-read:
  - The next cycle shows reset values on all outputs.
  - No further macro enables are driven until the state machine re-enters CLEAR or RUN.

## Test plan
- Reset and configuration: RST = 1 for 2 cycles, then CONFIGURED = 1 with CFG_CLEAR = 1.
  - Required: WEN all-ones with ADDR 0..1023 on consecutive cycles, BM all-ones, DIN 0.
  - F_BUSY falls 1025 cycles after CONFIGURED is sampled.
- Full mode with 2 banks: write 0xDEADBEEF to F_ADDR 0x405, then read it back.
  - Required: WEN[1], ADDR_SRAM = 0x005, BM = 0xFFFFFFFF.
  - F_VALID at n+2 with F_DOUT = 0xDEADBEEF. With CFG_OUTREG = 1, the pulse comes at n+3.
- Quarter mode: write 0xA5 to F_ADDR 0x0006.
  - Required: DIN = 0xA5A5A5A5, BM = 0x00FF0000, ADDR_SRAM = 1, bank 0.
  - A read of 0x0006 returns 0x000000A5.
- Simultaneous F_WEN and F_REN:
  - Required: only the write is issued and no F_VALID pulse occurs.
- Interruptions:
  - CONFIGURED dropped with a read in flight: no F_VALID, F_BUSY = 1 on the next cycle.
  - RST asserted mid-CLEAR: all enables are 0 on the next cycle.
- Out-of-range bank (NUM_BANKS = 3, bank index 3):
  - Required: no macro enable is driven; the read returns F_VALID with F_DOUT = 0.
